// File: rtl/ng_dsp_scan_if.sv
// ============================================================================
// ng_dsp_scan_if : scan-serializer link bundle (buffer side + display side)
// Revision 1.0
// ============================================================================
`default_nettype none

interface ng_dsp_scan_if;
   logic       EN;
   logic [7:0] DSP_IN;
   logic [3:0] SEL;
   logic       SCLK;
   logic       SDATA;
   logic       SLATCH;
   logic       BUSY;
   logic       FRAME_DONE;

   modport master (
      input  EN,
      input  DSP_IN,
      output SEL,
      output SCLK,
      output SDATA,
      output SLATCH,
      output BUSY,
      output FRAME_DONE
   );

   modport slave (
      output EN,
      output DSP_IN,
      input  SEL,
      input  SCLK,
      input  SDATA,
      input  SLATCH,
      input  BUSY,
      input  FRAME_DONE
   );
endinterface

`default_nettype wire

// File: rtl/ng_dsp_scan.sv
// ============================================================================
// ng_dsp_scan : display scan serializer, {SEL,DSP_IN} shifted MSB-first
// Revision 1.0
// ============================================================================
`default_nettype none

module ng_dsp_scan #(
   parameter int CLK_DIV   = 4,
   parameter int FRAME_GAP = 16,
   parameter int LAST_SEL  = 15
) (
   input  wire logic     CLK2,
   input  wire logic     RESET,
   ng_dsp_scan_if.master bus
);

   localparam logic [7:0]  c_DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [15:0] c_GAP_LAST = 16'(FRAME_GAP - 1);
   localparam logic [3:0]  c_LAST_SEL = 4'(LAST_SEL);
   localparam logic [7:0]  c_SETTLE_LAST = 8'd1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_LOAD   = 3'd2,
      S_SHIFT  = 3'd3,
      S_LATCH  = 3'd4,
      S_NEXT   = 3'd5,
      S_GAP    = 3'd6
   } state_t;

   state_t      r_state, w_state;
   logic [7:0]  r_div, w_div;
   logic [15:0] r_gap, w_gap;
   logic [3:0]  r_bit, w_bit;
   logic        r_phase, w_phase;
   logic [11:0] r_shreg, w_shreg;
   logic [3:0]  r_sel, w_sel;

   logic        r_sclk;
   logic        r_sdata;
   logic        r_slatch;
   logic        r_busy;
   logic        r_frame_done;

   always_comb begin
      w_state = r_state;
      w_div   = r_div;
      w_gap   = r_gap;
      w_bit   = r_bit;
      w_phase = r_phase;
      w_shreg = r_shreg;
      w_sel   = r_sel;
      case (r_state)
         S_IDLE: begin
            w_sel = 4'd0;
            if (bus.EN) begin
               w_state = S_SETTLE;
               w_div   = c_SETTLE_LAST;
            end
         end
         S_SETTLE: begin
            if (r_div == 8'd0) w_state = S_LOAD;
            else               w_div   = r_div - 8'd1;
         end
         S_LOAD: begin
            w_state = S_SHIFT;
            w_shreg = {r_sel, bus.DSP_IN};
            w_bit   = 4'd11;
            w_phase = 1'b0;
            w_div   = c_DIV_LAST;
         end
         S_SHIFT: begin
            // r_phase selects the low (0) or high (1) half of the bit
            if (r_div != 8'd0) begin
               w_div = r_div - 8'd1;
            end else if (!r_phase) begin
               w_phase = 1'b1;
               w_div   = c_DIV_LAST;
            end else if (r_bit == 4'd0) begin
               w_state = S_LATCH;
               w_phase = 1'b0;
               w_div   = c_DIV_LAST;
            end else begin
               w_bit   = r_bit - 4'd1;
               w_shreg = {r_shreg[10:0], 1'b0};
               w_phase = 1'b0;
               w_div   = c_DIV_LAST;
            end
         end
         S_LATCH: begin
            if (r_div == 8'd0) w_state = S_NEXT;
            else               w_div   = r_div - 8'd1;
         end
         S_NEXT: begin
            if (r_sel == c_LAST_SEL) begin
               w_sel   = 4'd0;
               w_state = S_GAP;
               w_gap   = c_GAP_LAST;
            end else begin
               w_sel   = r_sel + 4'd1;
               w_state = S_SETTLE;
               w_div   = c_SETTLE_LAST;
            end
         end
         S_GAP: begin
            if (r_gap == 16'd0) begin
               if (bus.EN) begin
                  w_state = S_SETTLE;
                  w_div   = c_SETTLE_LAST;
               end else begin
                  w_state = S_IDLE;
               end
            end else begin
               w_gap = r_gap - 16'd1;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with r_state
   always_ff @(posedge CLK2) begin
      if (RESET) begin
         r_state      <= S_IDLE;
         r_div        <= 8'd0;
         r_gap        <= 16'd0;
         r_bit        <= 4'd0;
         r_phase      <= 1'b0;
         r_shreg      <= 12'd0;
         r_sel        <= 4'd0;
         r_sclk       <= 1'b0;
         r_sdata      <= 1'b0;
         r_slatch     <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_div        <= w_div;
         r_gap        <= w_gap;
         r_bit        <= w_bit;
         r_phase      <= w_phase;
         r_shreg      <= w_shreg;
         r_sel        <= w_sel;
         r_sclk       <= (w_state == S_SHIFT) && w_phase;
         r_sdata      <= (w_state == S_SHIFT) && w_shreg[11];
         r_slatch     <= (w_state == S_LATCH);
         r_busy       <= (w_state != S_IDLE);
         r_frame_done <= (w_state == S_NEXT) && (r_sel == c_LAST_SEL);
      end
   end

   assign bus.SEL        = r_sel;
   assign bus.SCLK       = r_sclk;
   assign bus.SDATA      = r_sdata;
   assign bus.SLATCH     = r_slatch;
   assign bus.BUSY       = r_busy;
   assign bus.FRAME_DONE = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_ng_dsp_scan.sv
// ============================================================================
// tb_ng_dsp_scan : serial receiver + upstream buffer model around ng_dsp_scan
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ng_dsp_scan;

   localparam int CLK_DIV     = 4;
   localparam int FRAME_GAP   = 16;
   localparam int LAST_SEL    = 15;
   localparam int WORD        = 4 + 25 * CLK_DIV;
   localparam int FRAME       = (LAST_SEL + 1) * WORD + FRAME_GAP;
   localparam int FIRST_LATCH = 3 + 24 * CLK_DIV;
   localparam int LOAD_BACK   = 24 * CLK_DIV + 1;
   localparam int HN          = 16384;
   localparam int BUDGET      = 2000;

   localparam int Q_W   = 0;
   localparam int Q_LL  = 1;
   localparam int Q_FD  = 2;
   localparam int Q_FDW = 3;
   localparam int Q_BR  = 4;
   localparam int Q_BF  = 5;

   logic clk = 1'b0;
   logic RESET;
   always #5 clk = ~clk;

   ng_dsp_scan_if bus ();

   ng_dsp_scan #(
      .CLK_DIV  (CLK_DIV),
      .FRAME_GAP(FRAME_GAP),
      .LAST_SEL (LAST_SEL)
   ) u_dut (
      .CLK2 (clk),
      .RESET(RESET),
      .bus  (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  tbl [0:15];
   logic [7:0]  hist [0:HN-1];
   bit          mode = 1'b0;

   logic [11:0] w_q [$];
   int          nb_q [$];
   int          lr_q [$];
   int          ll_q [$];
   int          fd_q [$];
   int          fdw_q [$];
   int          br_q [$];
   int          bf_q [$];

   int          cyc = 0;
   logic [11:0] rx_sh = 12'd0;
   int          rx_n = 0;
   int          sclk_rises = 0;
   int          sdata_glitch = 0;
   int          lat_len = 0;
   int          fd_len = 0;
   logic        p_sclk = 1'b0, p_sdata = 1'b0, p_slatch = 1'b0, p_fd = 1'b0, p_busy = 1'b0;

   // Receiver board and upstream buffer, both on the falling edge
   always @(negedge clk) begin
      if (RESET === 1'b1) begin
         rx_sh = 12'd0;
         rx_n  = 0;
      end else if (bus.SCLK === 1'b1 && !p_sclk) begin
         rx_sh = {rx_sh[10:0], bus.SDATA};
         rx_n++;
         sclk_rises++;
      end
      if (bus.SCLK === 1'b1 && p_sclk && bus.SDATA !== p_sdata) sdata_glitch++;
      if (bus.SLATCH === 1'b1 && !p_slatch) begin
         w_q.push_back(rx_sh);
         nb_q.push_back(rx_n);
         lr_q.push_back(cyc);
         rx_sh   = 12'd0;
         rx_n    = 0;
         lat_len = 1;
      end else if (bus.SLATCH === 1'b1) begin
         lat_len++;
      end
      if (bus.SLATCH !== 1'b1 && p_slatch) ll_q.push_back(lat_len);
      if (bus.FRAME_DONE === 1'b1 && !p_fd) begin
         fd_q.push_back(cyc);
         fd_len = 1;
      end else if (bus.FRAME_DONE === 1'b1) begin
         fd_len++;
      end
      if (bus.FRAME_DONE !== 1'b1 && p_fd) fdw_q.push_back(fd_len);
      if (bus.BUSY === 1'b1 && !p_busy) br_q.push_back(cyc);
      if (bus.BUSY !== 1'b1 && p_busy) bf_q.push_back(cyc);
      bus.DSP_IN = mode ? 8'($urandom) : tbl[bus.SEL];
      hist[cyc % HN] = bus.DSP_IN;
      p_sclk   = (bus.SCLK === 1'b1);
      p_sdata  = bus.SDATA;
      p_slatch = (bus.SLATCH === 1'b1);
      p_fd     = (bus.FRAME_DONE === 1'b1);
      p_busy   = (bus.BUSY === 1'b1);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int which);
      case (which)
         Q_W:     return w_q.size();
         Q_LL:    return ll_q.size();
         Q_FD:    return fd_q.size();
         Q_FDW:   return fdw_q.size();
         Q_BR:    return br_q.size();
         default: return bf_q.size();
      endcase
   endfunction

   task automatic wait_for(input string tag, input int which);
      int n = 0;
      while (qsize(which) == 0 && n < BUDGET) begin
         @(posedge clk);
         n++;
      end
      if (qsize(which) == 0) begin
         compared++;
         mismatched++;
         $display("FAIL %s: observed timeout expected event within %0d cycles", tag, BUDGET);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
         $fatal(1, "timeout");
      end
   endtask

   task automatic clear_queues();
      w_q.delete(); nb_q.delete(); lr_q.delete(); ll_q.delete();
      fd_q.delete(); fdw_q.delete(); br_q.delete(); bf_q.delete();
   endtask

   // Expected word = {index, byte present on DSP_IN during the LOAD cycle}
   task automatic chk_word(input int k, input bit use_tbl, input string tag, output int lr);
      logic [11:0] w;
      logic [7:0]  d;
      int          nb, ll;
      wait_for({tag, "_word_wait"}, Q_W);
      wait_for({tag, "_latch_wait"}, Q_LL);
      w  = w_q.pop_front();
      nb = nb_q.pop_front();
      lr = lr_q.pop_front();
      ll = ll_q.pop_front();
      d  = use_tbl ? tbl[k] : hist[(lr - LOAD_BACK) % HN];
      chk({tag, "_word"}, 32'(w), 32'({k[3:0], d}));
      chk({tag, "_nbits"}, 32'(nb), 32'd12);
      chk({tag, "_latch_len"}, 32'(ll), 32'(CLK_DIV));
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_sel"},   32'(bus.SEL),        32'd0);
      chk({tag, "_sclk"},  32'(bus.SCLK),       32'd0);
      chk({tag, "_sdata"}, 32'(bus.SDATA),      32'd0);
      chk({tag, "_slatch"},32'(bus.SLATCH),     32'd0);
      chk({tag, "_busy"},  32'(bus.BUSY),       32'd0);
      chk({tag, "_fdone"}, 32'(bus.FRAME_DONE), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared + 1, mismatched + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, lr, prev, first_lr1, fd, s0, n;
      for (int i = 0; i < 16; i++) tbl[i] = 8'($urandom);
      tbl[0] = 8'h5A;

      RESET  = 1'b1;
      bus.EN = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("reset");
      RESET = 1'b0;
      @(negedge clk);
      chk("busy_after_release", 32'(bus.BUSY), 32'd1);

      // Frame 1: table data, word timing and frame timing
      wait_for("f1_start", Q_BR);
      t0 = br_q.pop_front();
      prev = 0;
      first_lr1 = 0;
      for (int k = 0; k <= LAST_SEL; k++) begin
         chk_word(k, 1'b1, "f1", lr);
         if (k == 0) begin
            chk("f1_first_latch", 32'(lr - t0), 32'(FIRST_LATCH));
            first_lr1 = lr;
         end else begin
            chk("f1_word_period", 32'(lr - prev), 32'(WORD));
         end
         prev = lr;
      end
      wait_for("f1_done", Q_FD);
      fd = fd_q.pop_front();
      chk("f1_done_offset", 32'(fd - t0), 32'((LAST_SEL + 1) * WORD - 1));
      wait_for("f1_done_width", Q_FDW);
      chk("f1_done_width", 32'(fdw_q.pop_front()), 32'd1);
      mode = 1'b1;

      // Frame 2: DSP_IN changes every cycle
      for (int k = 0; k <= LAST_SEL; k++) begin
         chk_word(k, 1'b0, "f2", lr);
         if (k == 0) chk("frame_period", 32'(lr - first_lr1), 32'(FRAME));
      end
      wait_for("f2_done", Q_FD);
      void'(fd_q.pop_front());
      mode = 1'b0;
      wait_for("f2_done_width", Q_FDW);
      chk("f2_done_width", 32'(fdw_q.pop_front()), 32'd1);

      // Frame 3: EN dropped in word 5 still completes the frame
      for (int k = 0; k <= 4; k++) chk_word(k, 1'b1, "f3", lr);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.EN = 1'b0;
      for (int k = 5; k <= LAST_SEL; k++) chk_word(k, 1'b1, "f3", lr);
      wait_for("f3_done", Q_FD);
      fd = fd_q.pop_front();
      wait_for("f3_idle", Q_BF);
      chk("f3_idle_after_gap", 32'(bf_q.pop_front() - fd), 32'(FRAME_GAP + 1));
      s0 = sclk_rises;
      repeat (300) @(posedge clk);
      @(negedge clk);
      chk("idle_no_sclk", 32'(sclk_rises - s0), 32'd0);
      chk("idle_busy", 32'(bus.BUSY), 32'd0);
      chk("idle_no_words", 32'(w_q.size()), 32'd0);

      // Frame 4: reset in the middle of word 3
      @(posedge clk);
      clear_queues();
      @(negedge clk);
      bus.EN = 1'b1;
      wait_for("f4_start", Q_BR);
      t0 = br_q.pop_front();
      for (int k = 0; k <= 2; k++) begin
         chk_word(k, 1'b1, "f4", lr);
         if (k == 0) chk("f4_first_latch", 32'(lr - t0), 32'(FIRST_LATCH));
      end
      n = 0;
      while (rx_n != 5 && n < BUDGET) begin
         @(posedge clk);
         n++;
      end
      chk("f4_reach_bit6", 32'(rx_n), 32'd5);
      @(negedge clk);
      RESET = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("msreset");
      @(posedge clk);
      clear_queues();
      @(negedge clk);
      RESET = 1'b0;
      @(negedge clk);
      chk("restart_busy", 32'(bus.BUSY), 32'd1);
      wait_for("restart_start", Q_BR);
      t0 = br_q.pop_front();
      chk_word(0, 1'b1, "restart", lr);
      chk("restart_first_latch", 32'(lr - t0), 32'(FIRST_LATCH));
      chk("sdata_stable_high", 32'(sdata_glitch), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
